// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared state encoding and default widths for the clock run controller
package clock_ctrl_pkg;
  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2} state_t;
  localparam int DIV_W = 8;
  localparam int STEP_W = 16;
  localparam int CNT_W = 32;
  localparam int ADDR_W = 16;
endpackage

// File: rtl/clock_prescaler.sv
// clock_prescaler: divide counter producing a tick when count reaches div_lat, then wrapping
module clock_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_lat,
  output logic             tick
);
  logic [DIV_W-1:0] count;
  always_comb tick = enable && count == div_lat;
  always_ff @(posedge clk) begin
    if (!rst_n || clear) count <= '0;
    else if (enable) count <= tick ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/clock_run_controller.sv
// clock_run_controller: run/halt/single-step clock-enable generator for the core.
// Define CLOCK_RUN_BREAKPOINT_EN to add the PC breakpoint (cpu_pc, bp_addr, bp_hit).
module clock_run_controller
  import clock_ctrl_pkg::*;
#(
  parameter int DIV_W = clock_ctrl_pkg::DIV_W,
  parameter int STEP_W = clock_ctrl_pkg::STEP_W,
`ifdef CLOCK_RUN_BREAKPOINT_EN
  parameter int ADDR_W = clock_ctrl_pkg::ADDR_W,
`endif
  parameter int CNT_W = clock_ctrl_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_count,
  input  logic [DIV_W-1:0]  div_ratio,
`ifdef CLOCK_RUN_BREAKPOINT_EN
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              bp_hit,
`endif
  output logic              cpu_ce,
  output logic              running,
  output logic              step_done,
  output logic [CNT_W-1:0]  ce_count
);
  state_t state, next_state;
  logic [DIV_W-1:0] div_lat, div_eff;
  logic [STEP_W-1:0] steps_left, steps_cur, steps_nxt;
  logic accept_run, accept_step, active, pre_en, tick, bp_trip;
`ifdef CLOCK_RUN_BREAKPOINT_EN
  assign bp_trip = state != HALT && cpu_ce && cpu_pc == bp_addr;
`else
  assign bp_trip = 1'b0;
`endif
  // The request cycle itself counts as prescaler phase 0, so the first pulse lands div+1 cycles later.
  always_comb begin
    accept_step = state == HALT && step_req && !halt_req;
    accept_run = state == HALT && run_req && !step_req && !halt_req;
    active = state != HALT && !halt_req && !bp_trip;
    pre_en = active || accept_run || (accept_step && step_count != '0);
    div_eff = state == HALT ? div_ratio : div_lat;
  end
  clock_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!pre_en),
    .enable  (pre_en),
    .div_lat (div_eff),
    .tick    (tick)
  );
  always_comb begin
    steps_cur = state == HALT ? step_count : steps_left;
    steps_nxt = steps_cur - STEP_W'(tick);
    next_state = state == HALT
      ? (accept_step ? (steps_nxt == '0 ? HALT : STEP) : accept_run ? RUN : HALT)
      : (!active || (state == STEP && steps_nxt == '0)) ? HALT : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HALT;
      cpu_ce <= 1'b0;
      running <= 1'b0;
      step_done <= 1'b0;
      ce_count <= '0;
      steps_left <= '0;
      div_lat <= '0;
    end else begin
      state <= next_state;
      cpu_ce <= tick;
      running <= next_state != HALT;
      step_done <= (accept_step || (state == STEP && active)) && steps_nxt == '0;
      ce_count <= ce_count + CNT_W'(tick);
      steps_left <= next_state == STEP ? steps_nxt : '0;
      if (accept_step || accept_run) div_lat <= div_ratio;
    end
  end
`ifdef CLOCK_RUN_BREAKPOINT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) bp_hit <= 1'b0;
    else if (bp_trip) bp_hit <= 1'b1;
    else if (accept_step || accept_run) bp_hit <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_clock_run_controller.sv
// tb_clock_run_controller: scoreboard bench; expected cpu_ce/step_done cycles are queued per request.
module tb_clock_run_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0;
  logic [15:0] step_count = '0;
  logic [7:0] div_ratio = '0;
  logic cpu_ce, running, step_done;
  logic [31:0] ce_count;
`ifdef CLOCK_RUN_BREAKPOINT_EN
  logic [15:0] cpu_pc = '0, bp_addr = '0;
  logic bp_hit;
`endif
  int checks = 0, errors = 0, cyc = 0;
  int ce_q[$], done_q[$];
  logic [31:0] exp_cnt = '0;

  always #5 clk = ~clk;

  clock_run_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .step_count (step_count),
    .div_ratio  (div_ratio),
`ifdef CLOCK_RUN_BREAKPOINT_EN
    .cpu_pc     (cpu_pc),
    .bp_addr    (bp_addr),
    .bp_hit     (bp_hit),
`endif
    .cpu_ce     (cpu_ce),
    .running    (running),
    .step_done  (step_done),
    .ce_count   (ce_count)
  );

  // Advance one clock and retire any scoreboard entries due this cycle.
  task automatic tick();
    logic pend;
    pend = cpu_ce;
    @(posedge clk);
    #1;
    cyc++;
`ifdef CLOCK_RUN_BREAKPOINT_EN
    if (pend) cpu_pc = cpu_pc + 16'd1;
`endif
    pend = ce_q.size() != 0 && ce_q[0] == cyc;
    checks++;
    if (cpu_ce !== pend) begin
      errors++;
      $display("FAIL cpu_ce cycle %0d got %b expected %b", cyc, cpu_ce, pend);
    end
    if (pend) begin
      void'(ce_q.pop_front());
      exp_cnt++;
    end
    pend = done_q.size() != 0 && done_q[0] == cyc;
    checks++;
    if (step_done !== pend) begin
      errors++;
      $display("FAIL step_done cycle %0d got %b expected %b", cyc, step_done, pend);
    end
    if (pend) void'(done_q.pop_front());
    checks++;
    if (ce_count !== exp_cnt) begin
      errors++;
      $display("FAIL ce_count cycle %0d got %0d expected %0d", cyc, ce_count, exp_cnt);
    end
  endtask

  task automatic test_drain(input string name);
    checks++;
    if (ce_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending pulses got %0d/%0d expected 0/0", name, ce_q.size(), done_q.size());
    end
    ce_q.delete();
    done_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    checks++;
    if ({cpu_ce, running, step_done} !== 3'b000 || ce_count !== 32'd0) begin
      errors++;
      $display("FAIL reset got ce=%b run=%b done=%b cnt=%0d expected all 0", cpu_ce, running, step_done, ce_count);
    end
    tick();
  endtask

  task automatic test_run_div0();
    div_ratio = 8'd0;
    for (int i = 1; i <= 10; i++) ce_q.push_back(i);
    cyc = 0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    repeat (9) tick();
    checks++;
    if (running !== 1'b1 || ce_count !== 32'd10) begin
      errors++;
      $display("FAIL run_div0 got running=%b cnt=%0d expected 1/10", running, ce_count);
    end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL run_div0_halt running got %b expected 0", running);
    end
    repeat (3) tick();
    test_drain("run_div0");
  endtask

  task automatic test_run_div3();
    div_ratio = 8'd3;
    ce_q.push_back(4);
    ce_q.push_back(8);
    ce_q.push_back(12);
    cyc = 0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    div_ratio = 8'd0;
    repeat (12) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL run_div3_halt running got %b expected 0", running);
    end
    repeat (6) tick();
    test_drain("run_div3");
  endtask

  task automatic test_step();
    div_ratio = 8'd1;
    step_count = 16'd5;
    for (int i = 1; i <= 5; i++) ce_q.push_back(2 * i);
    done_q.push_back(10);
    cyc = 0;
    step_req = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      step_req = 1'b0;
      checks++;
      if (running !== (k < 10)) begin
        errors++;
        $display("FAIL step running cycle %0d got %b expected %b", k, running, k < 10);
      end
    end
    test_drain("step");
  endtask

  task automatic test_step_abort();
    div_ratio = 8'd1;
    step_count = 16'd10;
    ce_q.push_back(2);
    ce_q.push_back(4);
    cyc = 0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (4) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL step_abort running got %b expected 0", running);
    end
    repeat (4) tick();
    test_drain("step_abort");
  endtask

  task automatic test_step_zero_and_priority();
    div_ratio = 8'd3;
    step_count = 16'd0;
    done_q.push_back(1);
    cyc = 0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL step_zero running got %b expected 0", running);
    end
    repeat (5) tick();
    test_drain("step_zero");
    div_ratio = 8'd0;
    step_count = 16'd2;
    ce_q.push_back(1);
    ce_q.push_back(2);
    done_q.push_back(2);
    cyc = 0;
    step_req = 1'b1;
    run_req = 1'b1;
    tick();
    step_req = 1'b0;
    run_req = 1'b0;
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL step_wins running cycle1 got %b expected 1", running);
    end
    tick();
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL step_wins running cycle2 got %b expected 0", running);
    end
    repeat (3) tick();
    test_drain("step_wins");
    cyc = 0;
    halt_req = 1'b1;
    step_req = 1'b1;
    run_req = 1'b1;
    tick();
    {halt_req, step_req, run_req} = 3'b000;
    repeat (3) tick();
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL halt_wins running got %b expected 0", running);
    end
    test_drain("halt_wins");
  endtask

  task automatic test_wrap_and_reset();
    force dut.ce_count = 32'hFFFF_FFFE;
    #1;
    release dut.ce_count;
    exp_cnt = 32'hFFFF_FFFE;
    div_ratio = 8'd0;
    ce_q.push_back(1);
    ce_q.push_back(2);
    ce_q.push_back(3);
    cyc = 0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();
    checks++;
    if (ce_count !== 32'd0) begin
      errors++;
      $display("FAIL wrap ce_count got %0d expected 0", ce_count);
    end
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    test_drain("wrap");
    step_count = 16'd10;
    for (int i = 1; i <= 3; i++) ce_q.push_back(i);
    cyc = 0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    ce_q.delete();
    done_q.delete();
    exp_cnt = '0;
    tick();
    checks++;
    if ({cpu_ce, running, step_done} !== 3'b000 || ce_count !== 32'd0) begin
      errors++;
      $display("FAIL mid_step_reset got ce=%b run=%b done=%b cnt=%0d expected all 0", cpu_ce, running, step_done, ce_count);
    end
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

`ifdef CLOCK_RUN_BREAKPOINT_EN
  task automatic test_breakpoint();
    bp_addr = 16'h0010;
    cpu_pc = 16'h000C;
    div_ratio = 8'd0;
    for (int i = 1; i <= 5; i++) ce_q.push_back(i);
    cyc = 0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    repeat (6) tick();
    checks++;
    if (bp_hit !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL breakpoint got bp_hit=%b running=%b expected 1/0", bp_hit, running);
    end
    test_drain("breakpoint");
    ce_q.push_back(1);
    cyc = 0;
    run_req = 1'b1;
    halt_req = 1'b0;
    tick();
    run_req = 1'b0;
    checks++;
    if (bp_hit !== 1'b0) begin
      errors++;
      $display("FAIL bp_clear got %b expected 0", bp_hit);
    end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    ce_q.delete();
    repeat (2) tick();
    test_drain("bp_resume");
  endtask
`endif

  initial begin
    test_reset();
    test_run_div0();
    test_run_div3();
    test_step();
    test_step_abort();
    test_step_zero_and_priority();
    test_wrap_and_reset();
`ifdef CLOCK_RUN_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
